// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: S-box, round constants, word/block
// types and the expander state encoding used by both key expanders.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} key_exp_state_e;

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
    int idx;
    idx = 255 - int'(x);
    return SBOX_TABLE[idx*8 +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic aes_word_t sub_word(input aes_word_t w);
    return {sbox_lookup(w[31:24]), sbox_lookup(w[23:16]),
            sbox_lookup(w[15:8]),  sbox_lookup(w[7:0])};
  endfunction

endpackage

// File: rtl/key_expand_inv_if.sv
// Load/readout bus of the inverse key expander, shared in shape with the
// forward expander so both sit behind the same controller.
interface key_expand_inv_if;
  import aes_pkg::*;

  logic       start;
  aes_word_t  last_key;
  logic [1:0] r_index;
  logic [3:0] round_key_num;
  aes_word_t  round_key;
  logic       done;

  modport master (output start, last_key, r_index, round_key_num,
                  input  round_key, done);
  modport slave  (input  start, last_key, r_index, round_key_num,
                  output round_key, done);
endinterface

// File: rtl/aes_inv_key_step.sv
// One backward step of the AES-128 key schedule: round key ctr -> round key ctr-1.
module aes_inv_key_step
  import aes_pkg::*;
(
  input  aes_block_t key,
  input  logic [3:0] rnd,
  output aes_block_t prev_key
);

  aes_word_t w0, w1, w2, w3;
  aes_word_t p0, p1, p2, p3;
  aes_word_t rot;

  always_comb begin
    w0  = key[127:96];
    w1  = key[95:64];
    w2  = key[63:32];
    w3  = key[31:0];
    p3  = w3 ^ w2;
    p2  = w2 ^ w1;
    p1  = w1 ^ w0;
    rot = {p3[23:0], p3[31:24]};
    p0  = w0 ^ sub_word(rot) ^ {rcon(rnd), 24'h0};
    prev_key = {p0, p1, p2, p3};
  end

endmodule

// File: rtl/key_expand_inv.sv
// Inverse AES-128 key schedule: load round key 10, regenerate rounds 9..0.
// Optional KEY_EXPAND_INV_ZEROIZE_EN clears key storage on reset and on start.
module key_expand_inv
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int WORD_W = 32
) (
  input logic             clk,
  input logic             reset,
  key_expand_inv_if.slave bus
);

  key_exp_state_e state, next_state;
  logic [1:0]     load_cnt;
  logic [3:0]     ctr;
  logic [95:0]    load_buf;
  aes_block_t     slots [0:NR];
  aes_block_t     cur_key, step_prev, sel_block;
  logic           load_wr, exp_wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // start always wins: it aborts any run in progress and restarts the load.
  always_comb begin
    next_state = state;
    if (bus.start) begin
      next_state = LOAD;
    end else begin
      case (state)
        LOAD:    if (load_cnt == 2'd3) next_state = EXPAND;
        EXPAND:  if (ctr == 4'd1) next_state = DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt <= '0;
      ctr      <= '0;
      load_buf <= '0;
    end else if (bus.start) begin
      load_buf[95:64] <= bus.last_key;
      load_cnt        <= 2'd1;
    end else begin
      case (state)
        LOAD: begin
          case (load_cnt)
            2'd1:    load_buf[63:32] <= bus.last_key;
            2'd2:    load_buf[31:0]  <= bus.last_key;
            default: ctr             <= 4'(NR);
          endcase
          load_cnt <= load_cnt + 2'd1;
        end
        EXPAND:  ctr <= ctr - 4'd1;
        default: ;
      endcase
    end
  end

  assign load_wr = !bus.start && (state == LOAD) && (load_cnt == 2'd3);
  assign exp_wr  = !bus.start && (state == EXPAND);

  aes_inv_key_step u_step (
    .key      (cur_key),
    .rnd      (ctr),
    .prev_key (step_prev)
  );

`ifdef KEY_EXPAND_INV_ZEROIZE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= NR; i++) slots[i] <= '0;
    end else if (bus.start) begin
      for (int i = 0; i <= NR; i++) slots[i] <= '0;
    end else if (load_wr) begin
      slots[NR] <= {load_buf, bus.last_key};
    end else if (exp_wr) begin
      slots[ctr - 4'd1] <= step_prev;
    end
  end
`else
  // Key storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (load_wr)     slots[NR]         <= {load_buf, bus.last_key};
    else if (exp_wr) slots[ctr - 4'd1] <= step_prev;
  end
`endif

  // Out-of-range round selects fall through to the zero default.
  always_comb begin
    cur_key   = '0;
    sel_block = '0;
    for (int i = 0; i <= NR; i++) begin
      if (ctr == 4'(i))               cur_key   = slots[i];
      if (bus.round_key_num == 4'(i)) sel_block = slots[i];
    end
  end

  assign bus.round_key = sel_block[bus.r_index*WORD_W +: WORD_W];
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_key_expand_inv.sv
// Self-checking bench for key_expand_inv: FIPS-197 vectors, forward-model
// round trip, abort, async reset; honours KEY_EXPAND_INV_ZEROIZE_EN.
module tb_key_expand_inv;

  typedef struct {
    logic [3:0]  rnd;
    logic [1:0]  idx;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  key_expand_inv_if bus ();

  key_expand_inv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  vec_t        exp_q [$];
  logic [7:0]  tb_sbox [256];
  logic [31:0] model_w [44];

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box rebuilt from the GF(2^8) inverse and the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word_m(input logic [31:0] w);
    return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
  endfunction

  task automatic fwd_model(input logic [127:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    model_w[0] = key[127:96];
    model_w[1] = key[95:64];
    model_w[2] = key[63:32];
    model_w[3] = key[31:0];
    for (int i = 4; i < 44; i++) begin
      t = model_w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      model_w[i] = model_w[i-4] ^ t;
    end
  endtask

  task automatic push_model();
    vec_t v;
    for (int r = 0; r <= 10; r++)
      for (int k = 0; k < 4; k++) begin
        v.rnd = 4'(r);
        v.idx = 2'(k);
        v.exp = model_w[4*r + (3 - k)];
        exp_q.push_back(v);
      end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that stores slot 10.
  task automatic apply_stimulus(input logic [127:0] k10, input bit probe_en, input logic [31:0] probe_exp);
    bus.start    = 1'b1;
    bus.last_key = k10[127:96];
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.last_key = k10[95:64];
    check_output("done_low_after_start", 32'(bus.done), 32'd0);
    if (probe_en) begin
      bus.round_key_num = 4'd0;
      bus.r_index       = 2'd3;
      #1;
      check_output("slot0_during_load", bus.round_key, probe_exp);
    end
    @(posedge clk); #1;
    bus.last_key = k10[63:32];
    @(posedge clk); #1;
    bus.last_key = k10[31:0];
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 4;
    while (!bus.done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check_output(name, 32'(n), 32'd14);
  endtask

  task automatic drain_queue();
    vec_t v;
    while (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      bus.round_key_num = v.rnd;
      bus.r_index       = v.idx;
      #1;
      check_output($sformatf("rk%0d_w%0d", v.rnd, v.idx), bus.round_key, v.exp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        fips_tab [14];
    vec_t        v;
    logic [127:0] rand_key;

    fips_tab[0]  = '{4'd0,  2'd3, 32'h2b7e1516};
    fips_tab[1]  = '{4'd0,  2'd2, 32'h28aed2a6};
    fips_tab[2]  = '{4'd0,  2'd1, 32'habf71588};
    fips_tab[3]  = '{4'd0,  2'd0, 32'h09cf4f3c};
    fips_tab[4]  = '{4'd9,  2'd3, 32'hac7766f3};
    fips_tab[5]  = '{4'd9,  2'd2, 32'h19fadc21};
    fips_tab[6]  = '{4'd9,  2'd1, 32'h28d12941};
    fips_tab[7]  = '{4'd9,  2'd0, 32'h575c006e};
    fips_tab[8]  = '{4'd1,  2'd3, 32'ha0fafe17};
    fips_tab[9]  = '{4'd1,  2'd2, 32'h88542cb1};
    fips_tab[10] = '{4'd1,  2'd1, 32'h23a33939};
    fips_tab[11] = '{4'd1,  2'd0, 32'h2a6c7605};
    fips_tab[12] = '{4'd10, 2'd3, 32'hd014f9a8};
    fips_tab[13] = '{4'd12, 2'd2, 32'h00000000};

    build_sbox();

    reset             = 1'b1;
    bus.start         = 1'b0;
    bus.last_key      = '0;
    bus.r_index       = 2'd0;
    bus.round_key_num = 4'd12;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_done", 32'(bus.done), 32'd0);
    check_output("reset_rk12", bus.round_key, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] FIPS-197 A.1 run");
    for (int i = 0; i < 14; i++) exp_q.push_back(fips_tab[i]);
    apply_stimulus(FIPS_K10, 1'b0, 32'h0);
    wait_done("fips_done_latency");
    drain_queue();

    $display("[TB] random round trip from DONE");
    rand_key = {$urandom, $urandom, $urandom, $urandom};
    fwd_model(rand_key);
    push_model();
`ifdef KEY_EXPAND_INV_ZEROIZE_EN
    apply_stimulus({model_w[40], model_w[41], model_w[42], model_w[43]}, 1'b1, 32'h0);
`else
    apply_stimulus({model_w[40], model_w[41], model_w[42], model_w[43]}, 1'b1, 32'h2b7e1516);
`endif
    wait_done("rand_done_latency");
    drain_queue();

    $display("[TB] abort during EXPAND");
    apply_stimulus(FIPS_K10, 1'b0, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    check_output("abort_done_low", 32'(bus.done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      v = '{4'd0, 2'(k), 32'h0};
      exp_q.push_back(v);
      v = '{4'd1, 2'(k), 32'h62636363};
      exp_q.push_back(v);
      v = '{4'd10, 2'(k), ZERO_K10[k*32 +: 32]};
      exp_q.push_back(v);
    end
    apply_stimulus(ZERO_K10, 1'b0, 32'h0);
    wait_done("abort_done_latency");
    drain_queue();

    $display("[TB] async reset from DONE");
    bus.round_key_num = 4'd10;
    bus.r_index       = 2'd0;
    #2 reset = 1'b1;
    #1;
    check_output("reset_async_done", 32'(bus.done), 32'd0);
`ifdef KEY_EXPAND_INV_ZEROIZE_EN
    check_output("reset_slot10", bus.round_key, 32'h0);
`else
    check_output("reset_slot10", bus.round_key, 32'h6f8f188e);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] reset during EXPAND");
    apply_stimulus(FIPS_K10, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("reset_expand_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check_output("idle_stays_not_done", 32'(bus.done), 32'd0);
    bus.round_key_num = 4'd10;
    bus.r_index       = 2'd3;
    #1;
`ifdef KEY_EXPAND_INV_ZEROIZE_EN
    check_output("reset_expand_slot10", bus.round_key, 32'h0);
`else
    check_output("reset_expand_slot10", bus.round_key, 32'hd014f9a8);
`endif
    bus.round_key_num = 4'd12;
    #1;
    check_output("rk12_zero", bus.round_key, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
